// File: rtl/const_unit_scheduler.sv
// const_unit_scheduler
//   Shares a single constant (immediate) unit between two requesters:
//   requester 0 is decode, requester 1 is the branch/CSR path. Requests are
//   granted round-robin and only one transaction is ever in flight. For each
//   transaction the winning word is latched onto cu_im, cu_cs is pulsed for
//   one cycle, and CU_LAT cycles later cu_data is captured and returned to
//   the winner as a one-cycle response pulse.
//
// Parameters
//   IW      instruction / immediate-source word width (cu_im width)
//   DW      constant-unit result width (cu_data, rspN_data width)
//   CU_LAT  cycles from the cu_cs cycle to a valid cu_data, 1..15
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               synchronous active-low reset
//   req0_valid/req0_im  requester 0 request and its instruction word
//   req0_ready          requester 0 accepted this cycle (combinational)
//   rsp0_valid          one-cycle pulse, rsp0_data valid
//   rsp0_data           constant returned to requester 0 (held until next)
//   req1_* / rsp1_*     same as above for requester 1
//   cu_im               word presented to the constant unit
//   cu_cs               constant-unit select, one pulse per transaction
//   cu_data             constant-unit result, valid CU_LAT cycles after cu_cs

module const_unit_scheduler #(
  parameter int IW     = 17,
  parameter int DW     = 6,
  parameter int CU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [IW-1:0] req0_im,
  output logic          req0_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  input  logic          req1_valid,
  input  logic [IW-1:0] req1_im,
  output logic          req1_ready,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic [IW-1:0] cu_im,
  output logic          cu_cs,
  input  logic [DW-1:0] cu_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(CU_LAT - 1);

  state_t     state;
  logic       rr_ptr;    // 0: req0 wins a tie, 1: req1 wins a tie
  logic       owner;     // requester that owns the in-flight transaction
  logic [3:0] wait_cnt;
  logic       grant0;
  logic       grant1;

  // Grants are only offered in IDLE. A lone requester always wins; on a
  // tie the pointer decides. The two grants are mutually exclusive.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || !rr_ptr)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      cu_cs      <= 1'b0;
      cu_im      <= '0;
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
    end else begin
      // Pulsed outputs default low; each is raised for exactly one cycle.
      cu_cs      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            // The word is sampled only here; cu_im then holds until the
            // next accept. cu_cs is registered so it is high during ISSUE.
            cu_im  <= grant1 ? req1_im : req0_im;
            owner  <= grant1;
            rr_ptr <= grant0;
            cu_cs  <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= LAT_M1;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            // cu_data is only looked at on this edge.
            if (owner) begin
              rsp1_data  <= cu_data;
              rsp1_valid <= 1'b1;
            end else begin
              rsp0_data  <= cu_data;
              rsp0_valid <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_const_unit_scheduler.sv
module tb_const_unit_scheduler;

  logic clk;
  logic rst_n;

  // Instance with CU_LAT=1
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [16:0] req0_im, req1_im, cu_im;
  logic        rsp0_valid, rsp1_valid, cu_cs;
  logic [5:0]  rsp0_data, rsp1_data, cu_data;

  // Instance with CU_LAT=4
  logic        l4_req0_valid, l4_req1_valid, l4_req0_ready, l4_req1_ready;
  logic [16:0] l4_req0_im, l4_req1_im, l4_cu_im;
  logic        l4_rsp0_valid, l4_rsp1_valid, l4_cu_cs;
  logic [5:0]  l4_rsp0_data, l4_rsp1_data, l4_cu_data;

  typedef struct packed {
    logic       id;
    logic [5:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t sb4[$];
  int   total = 0;
  int   bad = 0;

  const_unit_scheduler #(.IW(17), .DW(6), .CU_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_im(req0_im), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_im(req1_im), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .cu_im(cu_im), .cu_cs(cu_cs), .cu_data(cu_data)
  );

  const_unit_scheduler #(.IW(17), .DW(6), .CU_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(l4_req0_valid), .req0_im(l4_req0_im), .req0_ready(l4_req0_ready),
    .rsp0_valid(l4_rsp0_valid), .rsp0_data(l4_rsp0_data),
    .req1_valid(l4_req1_valid), .req1_im(l4_req1_im), .req1_ready(l4_req1_ready),
    .rsp1_valid(l4_rsp1_valid), .rsp1_data(l4_rsp1_data),
    .cu_im(l4_cu_im), .cu_cs(l4_cu_cs), .cu_data(l4_cu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Constant-unit models: result is cu_im[5:0] exactly CU_LAT cycles after
  // the cu_cs cycle, and an inverted (wrong) value at any other time.
  logic [3:0] sr1 = '0;
  logic [3:0] sr4 = '0;
  always @(posedge clk) begin
    sr1 <= {sr1[2:0], cu_cs};
    sr4 <= {sr4[2:0], l4_cu_cs};
  end
  assign cu_data    = sr1[0] ? cu_im[5:0]    : ~cu_im[5:0];
  assign l4_cu_data = sr4[3] ? l4_cu_im[5:0] : ~l4_cu_im[5:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, land 1 time unit after the edge, and score any
  // response against the head of the matching expectation queue.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (rsp0_valid === 1'b1 || rsp1_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_owner", {30'd0, rsp1_valid, rsp0_valid}, e.id ? 32'd2 : 32'd1);
        check("rsp_data", e.id ? {26'd0, rsp1_data} : {26'd0, rsp0_data}, {26'd0, e.data});
      end
    end
    if (l4_rsp0_valid === 1'b1 || l4_rsp1_valid === 1'b1) begin
      if (sb4.size() == 0) begin
        check("l4_rsp_unexpected", {30'd0, l4_rsp1_valid, l4_rsp0_valid}, 32'd0);
      end else begin
        e = sb4.pop_front();
        check("l4_rsp_owner", {30'd0, l4_rsp1_valid, l4_rsp0_valid}, e.id ? 32'd2 : 32'd1);
        check("l4_rsp_data", e.id ? {26'd0, l4_rsp1_data} : {26'd0, l4_rsp0_data}, {26'd0, e.data});
      end
    end
  endtask

  initial begin
    bit got;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_im = '0; req1_im = '0;
    l4_req0_valid = 1'b0; l4_req1_valid = 1'b0; l4_req0_im = '0; l4_req1_im = '0;
    tick();
    tick();

    // Reset state
    check("rst_cu_cs", cu_cs, 0);
    check("rst_cu_im", cu_im, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp0_data", rsp0_data, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_rsp1_data", rsp1_data, 0);
    check("rst_l4_cu_cs", l4_cu_cs, 0);
    rst_n = 1'b1;

    // 1: single req0, CU_LAT=1
    req0_valid = 1'b1; req0_im = 17'h0002A;
    #1;
    check("t1_ready", {req1_ready, req0_ready}, 2'b01);
    tick();
    sb.push_back(exp_t'({1'b0, 6'h2A}));
    req0_valid = 1'b0;
    check("t1_cs_T1", cu_cs, 1);
    check("t1_cu_im", cu_im, 17'h0002A);
    tick();
    check("t1_cs_T2", cu_cs, 0);
    check("t1_rsp0_T2", rsp0_valid, 0);
    tick();
    check("t1_rsp0_T3", rsp0_valid, 1);
    check("t1_rsp1_T3", rsp1_valid, 0);
    check("t1_data_T3", rsp0_data, 6'h2A);
    tick();
    check("t1_rsp0_T4", rsp0_valid, 0);
    check("t1_hold_T4", rsp0_data, 6'h2A);

    // 2: both valid from reset, strict alternation over 6 transactions
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_im = 17'h00011;
    req1_valid = 1'b1; req1_im = 17'h00022;
    for (int n = 0; n < 6; n++) begin
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        #1;
        if (req0_ready || req1_ready) begin
          got = 1'b1;
          check("t2_grant", {req1_ready, req0_ready}, (n % 2) ? 2'b10 : 2'b01);
          if (n > 0) check("t2_spacing", w, 3);
          sb.push_back((n % 2) ? exp_t'({1'b1, 6'h22}) : exp_t'({1'b0, 6'h11}));
        end
        tick();
      end
      if (!got) check("t2_timeout", 0, 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t2_drained", sb.size(), 0);
    check("t2_rsp0_data", rsp0_data, 6'h11);
    check("t2_rsp1_data", rsp1_data, 6'h22);

    // 4: req0 held during a req1 transaction
    req1_valid = 1'b1; req1_im = 17'h1ABCD;
    #1;
    check("t4_ready1", {req1_ready, req0_ready}, 2'b10);
    tick();
    sb.push_back(exp_t'({1'b1, 6'h0D}));
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_im = 17'h00033;
    for (int k = 1; k <= 3; k++) begin
      #1;
      check("t4_ready0_busy", req0_ready, 0);
      check("t4_cu_im_hold", cu_im, 17'h1ABCD);
      tick();
    end
    #1;
    check("t4_ready0_idle", {req1_ready, req0_ready}, 2'b01);
    tick();
    sb.push_back(exp_t'({1'b0, 6'h33}));
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t4_drained", sb.size(), 0);

    // 5: reset during WAIT drops the transaction
    req0_valid = 1'b1; req0_im = 17'h00007;
    #1;
    check("t5_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("t5_cu_cs", cu_cs, 0);
    check("t5_cu_im", cu_im, 0);
    check("t5_rsp0_valid", rsp0_valid, 0);
    check("t5_rsp0_data", rsp0_data, 0);
    check("t5_rsp1_valid", rsp1_valid, 0);
    check("t5_rsp1_data", rsp1_data, 0);
    rst_n = 1'b1;
    tick();
    check("t5_no_rsp_a", rsp0_valid, 0);
    tick();
    check("t5_no_rsp_b", rsp0_valid, 0);
    req0_valid = 1'b1; req0_im = 17'h15555;
    #1;
    check("t5_ready_after", {req1_ready, req0_ready}, 2'b01);
    tick();
    sb.push_back(exp_t'({1'b0, 6'h15}));
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_drained", sb.size(), 0);
    check("t5_data_after", rsp0_data, 6'h15);

    // 6: req0 valid pulsed with changing im while not ready
    req1_valid = 1'b1; req1_im = 17'h00024;
    #1;
    check("t6_ready1", req1_ready, 1);
    tick();
    sb.push_back(exp_t'({1'b1, 6'h24}));
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_im = 17'h00001;
    tick();
    req0_valid = 1'b0; req0_im = 17'h00002;
    tick();
    req0_valid = 1'b1; req0_im = 17'h00003;
    #1;
    check("t6_not_ready", req0_ready, 0);
    tick();
    req0_im = 17'h0003C;
    #1;
    check("t6_ready0", req0_ready, 1);
    tick();
    sb.push_back(exp_t'({1'b0, 6'h3C}));
    req0_valid = 1'b0; req0_im = 17'h00005;
    check("t6_cu_im", cu_im, 17'h0003C);
    for (int i = 0; i < 4; i++) tick();
    check("t6_drained", sb.size(), 0);

    // 3: CU_LAT=4, req1 alone
    l4_req1_valid = 1'b1; l4_req1_im = 17'h1FFFF;
    #1;
    check("t3_ready", {l4_req1_ready, l4_req0_ready}, 2'b10);
    tick();
    sb4.push_back(exp_t'({1'b1, 6'h3F}));
    l4_req1_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check("t3_cu_cs", l4_cu_cs, (k == 1));
      check("t3_rsp1_valid", l4_rsp1_valid, (k == 6));
      check("t3_rsp0_valid", l4_rsp0_valid, 0);
      if (k == 6) check("t3_rsp1_data", l4_rsp1_data, 6'h3F);
      tick();
    end
    check("t3_drained", sb4.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
